control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 36 +++
 rtl/control_unit_decode.sv | 66 ++++++
 rtl/control_unit.sv | 63 ++++++
 tb/tb_control_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Purpose: shared opcode, ALU-op and control-vector definitions for the control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: OP_* opcode constants, ALU_* operation encodings, ctrl_t packed control vector, CTRL_NOP.
package control_unit_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_LW     = 3'b100;
    localparam logic [2:0] OP_SW     = 3'b101;
    localparam logic [2:0] OP_ADDI   = 3'b110;
    localparam logic [2:0] OP_ORI    = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Field order matches the published decode table, MSB first.
    typedef struct packed {
        logic       regDst;
        logic       regWrite;
        logic       memToReg;
        logic       memWrite;
        logic       memRead;
        logic       aluSrc;
        logic       extOp;
        logic       branch;
        logic [1:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_unit_decode.sv
// Purpose: combinational opcode-to-control-vector decode table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; accepts a new opcode every cycle.
// Ports: opcode (3-bit instruction opcode) -> ctrl (packed control vector).
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic [2:0] opcode,
    output ctrl_t      ctrl
);

    // Every field starts at 0 so unused fields of an instruction are driven low;
    // an opcode carrying X/Z matches no item and falls to the NOP default.
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_ADD: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_SUB: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_SUB;
            end
            OP_BRANCH: begin
                ctrl.extOp    = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.aluOp    = ALU_SUB;
            end
            OP_AND: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_AND;
            end
            OP_LW: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.extOp    = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.extOp    = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.extOp    = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_ORI: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_OR;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Purpose: single-cycle datapath control unit: opcode decode with optional output register.
// Latency: 1 cycle when OUT_REG=1, 0 cycles (combinational) when OUT_REG=0.
// Backpressure: none; one opcode per cycle, reset forces the NOP vector asynchronously.
// Ports: clk, rst_n (async active-low), opcode[2:0] -> RegDst, RegWrite, MemToReg, MemWrite,
//        MemRead, ALUsrc, ExtOp, Branch, ALUop[1:0].
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       ALUsrc,
    output logic       ExtOp,
    output logic       Branch,
    output logic [1:0] ALUop
);

    ctrl_t decoded;
    ctrl_t ctrlOut;

    control_unit_decode uDecode (
        .opcode (opcode),
        .ctrl   (decoded)
    );

    generate
        if (OUT_REG != 0) begin : gReg
            ctrl_t ctrlQ;

            // Async clear makes the NOP vector appear the moment reset asserts,
            // independent of where the clock is.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctrlQ <= CTRL_NOP;
                end else begin
                    ctrlQ <= decoded;
                end
            end

            assign ctrlOut = ctrlQ;
        end else begin : gComb
            assign ctrlOut = decoded;
        end
    endgenerate

    assign RegDst   = ctrlOut.regDst;
    assign RegWrite = ctrlOut.regWrite;
    assign MemToReg = ctrlOut.memToReg;
    assign MemWrite = ctrlOut.memWrite;
    assign MemRead  = ctrlOut.memRead;
    assign ALUsrc   = ctrlOut.aluSrc;
    assign ExtOp    = ctrlOut.extOp;
    assign Branch   = ctrlOut.branch;
    assign ALUop    = ctrlOut.aluOp;

endmodule

// File: tb/tb_control_unit.sv
// Purpose: self-checking bench for control_unit with the default registered outputs.
// Latency: expects decoded vectors one clk after the opcode is sampled.
// Backpressure: n/a.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       RegDst, RegWrite, MemToReg, MemWrite, MemRead, ALUsrc, ExtOp, Branch;
    logic [1:0] ALUop;

    int total = 0;
    int bad   = 0;

    control_unit #(.OUT_REG(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ALUsrc   (ALUsrc),
        .ExtOp    (ExtOp),
        .Branch   (Branch),
        .ALUop    (ALUop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [8];

    // Observed vector in table order:
    // RegDst,RegWrite,MemToReg,MemWrite,MemRead,ALUsrc,ExtOp,Branch,ALUop
    function automatic logic [9:0] actual();
        return {RegDst, RegWrite, MemToReg, MemWrite, MemRead, ALUsrc, ExtOp, Branch, ALUop};
    endfunction

    // Reference built from instruction classes rather than a per-opcode table.
    function automatic logic [9:0] model(input logic [2:0] op);
        bit isR, isLw, isSw, isBr, isAddi, isOri, isSub, isAnd;
        logic [1:0] alu;
        isSub  = (op == 3'd1);
        isAnd  = (op == 3'd3);
        isR    = (op == 3'd0) || isSub || isAnd;
        isBr   = (op == 3'd2);
        isLw   = (op == 3'd4);
        isSw   = (op == 3'd5);
        isAddi = (op == 3'd6);
        isOri  = (op == 3'd7);
        alu = (isSub || isBr) ? 2'b01 : isAnd ? 2'b10 : isOri ? 2'b11 : 2'b00;
        return {isR,
                isR || isLw || isAddi || isOri,
                isLw,
                isSw,
                isLw,
                isLw || isSw || isAddi || isOri,
                isLw || isSw || isAddi || isBr,
                isBr,
                alu};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] prev;
        logic [2:0] r;

        tbl[0] = '{3'b000, 10'b1100000000};
        tbl[1] = '{3'b001, 10'b1100000001};
        tbl[2] = '{3'b010, 10'b0000001101};
        tbl[3] = '{3'b011, 10'b1100000010};
        tbl[4] = '{3'b100, 10'b0110111000};
        tbl[5] = '{3'b101, 10'b0001011000};
        tbl[6] = '{3'b110, 10'b0100011000};
        tbl[7] = '{3'b111, 10'b0100010011};

        // Reset held with lw on the bus: outputs stay NOP across edges.
        rst_n  = 1'b0;
        opcode = 3'b100;
        #2;
        chk("reset_initial", actual(), 10'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_held", actual(), 10'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_no_edge", actual(), 10'd0);
        step();
        chk("first_after_release_lw", actual(), tbl[4].exp);

        // Sweep: new opcode must not show before the edge, and must show right after it.
        prev = tbl[4].exp;
        for (int i = 0; i < 8; i++) begin
            opcode = tbl[i].op;
            #1;
            chk("sweep_hold_before_edge", actual(), prev);
            step();
            chk("sweep_vector", actual(), tbl[i].exp);
            prev = tbl[i].exp;
        end

        // Branch fields.
        opcode = 3'b010;
        step();
        chk("branch_fields", {Branch, ALUop, ExtOp, RegWrite, MemWrite}, 10'b00000_1_01_1_0_0);

        // ori then addi: extension and ALU op flip, immediate operand kept.
        opcode = 3'b111;
        step();
        chk("ori_fields", {ExtOp, ALUop, ALUsrc}, 10'b000000_0_11_1);
        opcode = 3'b110;
        step();
        chk("addi_fields", {ExtOp, ALUop, ALUsrc}, 10'b000000_1_00_1);

        // Reset asserted between edges must clear outputs without a clock.
        opcode = 3'b000;
        step();
        chk("add_before_midreset", actual(), tbl[0].exp);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcycle_reset_async", actual(), 10'd0);
        step();
        chk("midcycle_reset_held", actual(), 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("recover_after_midreset", actual(), tbl[0].exp);

        // Random stream against the class-based reference plus exclusivity rules.
        for (int i = 0; i < 1000; i++) begin
            r = 3'($urandom_range(0, 7));
            opcode = r;
            step();
            chk("random_vector", actual(), model(r));
            chk("excl_memrd_memwr", {9'd0, MemRead & MemWrite}, 10'd0);
            chk("excl_memwr_regwr", {9'd0, MemWrite & RegWrite}, 10'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
